mbist_march_ctrl: RTL and testbench

MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

---
 rtl/mbist_pkg.sv | 37 +++
 rtl/march_addr_gen.sv | 38 +++
 rtl/mbist_march_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// Shared types and March C- tables for the MBIST march controller.
// Element tables are indexed by elem_t; bit n describes element Mn.
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } elem_t;

    localparam logic [7:0] BG0 = 8'h00;
    localparam logic [7:0] BG1 = 8'h0F;
    localparam logic [7:0] BG2 = 8'h33;
    localparam logic [7:0] BG3 = 8'h55;
    localparam logic [3:0][7:0] BG_PAT = {BG3, BG2, BG1, BG0};

    // Direction: 1 = ascending addresses.
    localparam logic [5:0] ELEM_UP     = 6'b100111;
    // Elements M1..M4 have a read followed by a write; M0 and M5 have one op.
    localparam logic [5:0] ELEM_TWO_OP = 6'b011110;
    // First op is a read for every element except M0.
    localparam logic [5:0] OP0_RD      = 6'b111110;
    // Data polarity (1 = complement of background) of the first and second op.
    localparam logic [5:0] OP0_INV     = 6'b010100;
    localparam logic [5:0] OP1_INV     = 6'b001010;

endpackage

// File: rtl/march_addr_gen.sv
// Up/down address counter with parallel load; tc_o flags the last address
// in the current direction.
module march_addr_gen #(
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              en_i,
    input  logic              up_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              tc_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_val_i;
        end else if (en_i) begin
            addr_d = up_i ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign tc_o   = up_i ? (addr_q == '1) : (addr_q == '0);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller over four data backgrounds, one RAM
// operation per cycle, with first-failure capture and a saturating count.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 8,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_rwbar,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [1:0]        fail_bg,
    output logic [7:0]        fail_cnt,
    output state_t            dbg_state
);

    function automatic logic [DATA_W-1:0] bg_word(input logic [1:0] idx);
        logic [7:0] pat;
        pat = BG_PAT[idx];
        bg_word = '0;
        for (int i = 0; i < DATA_W; i++) begin
            bg_word[i] = pat[3'(i)];
        end
    endfunction

    state_t            state_q, state_d;
    elem_t             elem_q, elem_d, next_elem;
    logic              op_q, op_d;
    logic [1:0]        bg_q, bg_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              cmp_vld_q, cmp_vld_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [2:0]        cmp_elem_q, cmp_elem_d;
    logic [1:0]        cmp_bg_q, cmp_bg_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]        fail_elem_q, fail_elem_d;
    logic [1:0]        fail_bg_q, fail_bg_d;
    logic [7:0]        fail_cnt_q, fail_cnt_d;

    logic              ag_load, ag_en, ag_up, ag_tc;
    logic [ADDR_W-1:0] ag_load_val, ag_addr;

    logic              op_rd, op_inv, last_op, miscmp;
    logic [DATA_W-1:0] op_data;

    march_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (ag_load),
        .load_val_i (ag_load_val),
        .en_i       (ag_en),
        .up_i       (ag_up),
        .addr_o     (ag_addr),
        .tc_o       (ag_tc)
    );

    assign next_elem = elem_t'(elem_q + 3'd1);
    assign ag_up     = ELEM_UP[elem_q];
    assign op_rd     = op_q ? 1'b0 : OP0_RD[elem_q];
    assign op_inv    = op_q ? OP1_INV[elem_q] : OP0_INV[elem_q];
    assign op_data   = bg_word(bg_q) ^ {DATA_W{op_inv}};
    assign last_op   = op_q | ~ELEM_TWO_OP[elem_q];
    // Read data returns one cycle after the read, so it is checked while the next op issues.
    assign miscmp    = cmp_vld_q && (ram_rdata != exp_q);

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        op_d        = op_q;
        bg_d        = bg_q;
        exp_d       = exp_q;
        cmp_vld_d   = 1'b0;
        cmp_addr_d  = cmp_addr_q;
        cmp_elem_d  = cmp_elem_q;
        cmp_bg_d    = cmp_bg_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        fail_bg_d   = fail_bg_q;
        fail_cnt_d  = fail_cnt_q;
        ag_load     = 1'b0;
        ag_load_val = '0;
        ag_en       = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        ram_rwbar   = 1'b1;

        if (miscmp) begin
            fail_d = 1'b1;
            if (fail_cnt_q != 8'hFF) begin
                fail_cnt_d = fail_cnt_q + 8'd1;
            end
            if (!fail_q) begin
                fail_addr_d = cmp_addr_q;
                fail_elem_d = cmp_elem_q;
                fail_bg_d   = cmp_bg_q;
            end
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    elem_d      = M0;
                    op_d        = 1'b0;
                    bg_d        = 2'd0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                    fail_bg_d   = '0;
                    fail_cnt_d  = '0;
                    ag_load     = 1'b1;
                end
            end
            ST_RUN: begin
                ram_addr  = ag_addr;
                ram_rwbar = op_rd;
                ram_wdata = op_rd ? '0 : op_data;
                if ((STOP_ON_FAIL != 0) && miscmp) begin
                    ram_rwbar = 1'b1;
                    ram_wdata = '0;
                    state_d   = ST_DONE;
                end else begin
                    if (op_rd) begin
                        cmp_vld_d  = 1'b1;
                        exp_d      = op_data;
                        cmp_addr_d = ag_addr;
                        cmp_elem_d = elem_q;
                        cmp_bg_d   = bg_q;
                    end
                    if (!last_op) begin
                        op_d = 1'b1;
                    end else begin
                        op_d = 1'b0;
                        if (!ag_tc) begin
                            ag_en = 1'b1;
                        end else if (elem_q == M5) begin
                            elem_d  = M0;
                            ag_load = 1'b1;
                            if (bg_q == 2'd3) begin
                                state_d = ST_CHECK;
                            end else begin
                                bg_d = bg_q + 2'd1;
                            end
                        end else begin
                            elem_d      = next_elem;
                            ag_load     = 1'b1;
                            ag_load_val = ELEM_UP[next_elem] ? '0 : '1;
                        end
                    end
                end
            end
            ST_CHECK: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            elem_q      <= M0;
            op_q        <= 1'b0;
            bg_q        <= 2'd0;
            exp_q       <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= '0;
            cmp_bg_q    <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_bg_q   <= '0;
            fail_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            op_q        <= op_d;
            bg_q        <= bg_d;
            exp_q       <= exp_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_elem_q  <= cmp_elem_d;
            cmp_bg_q    <= cmp_bg_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_bg_q   <= fail_bg_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign busy      = (state_q == ST_RUN) || (state_q == ST_CHECK);
    assign done      = (state_q == ST_DONE);
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign fail_bg   = fail_bg_q;
    assign fail_cnt  = fail_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: two instances (STOP_ON_FAIL 0 and 1), each
// on a 64x8 RAM model with an optional stuck-at cell.
module tb_mbist_march_ctrl;

  logic clk;
  logic rst0, rst1, start0, start1;
  logic [5:0] ram_addr0, ram_addr1, fail_addr0, fail_addr1;
  logic [7:0] ram_wdata0, ram_wdata1, rdata0, rdata1, fail_cnt0, fail_cnt1;
  logic ram_rwbar0, ram_rwbar1, busy0, busy1, done0, done1, fail0, fail1;
  logic [2:0] fail_elem0, fail_elem1;
  logic [1:0] fail_bg0, fail_bg1;
  mbist_pkg::state_t dbg0, dbg1;

  int checks = 0;
  int failures = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mbist_march_ctrl #(.ADDR_W(6), .DATA_W(8), .STOP_ON_FAIL(0)) dut0 (
    .clk(clk), .rst(rst0), .start(start0),
    .ram_addr(ram_addr0), .ram_wdata(ram_wdata0), .ram_rwbar(ram_rwbar0),
    .ram_rdata(rdata0), .busy(busy0), .done(done0), .fail(fail0),
    .fail_addr(fail_addr0), .fail_elem(fail_elem0), .fail_bg(fail_bg0),
    .fail_cnt(fail_cnt0), .dbg_state(dbg0)
  );

  mbist_march_ctrl #(.ADDR_W(6), .DATA_W(8), .STOP_ON_FAIL(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_rwbar(ram_rwbar1),
    .ram_rdata(rdata1), .busy(busy1), .done(done1), .fail(fail1),
    .fail_addr(fail_addr1), .fail_elem(fail_elem1), .fail_bg(fail_bg1),
    .fail_cnt(fail_cnt1), .dbg_state(dbg1)
  );

  // ---------------- RAM models with one stuck-at cell ----------------
  bit f_en = 1'b0;
  logic [5:0] f_addr = '0;
  int f_bit = 0;
  bit f_val = 1'b0;
  logic [7:0] mem0 [64];
  logic [7:0] mem1 [64];

  function automatic logic [7:0] apply_fault(input logic [5:0] a, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (f_en && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (!ram_rwbar0) mem0[ram_addr0] <= ram_wdata0;
    rdata0 <= apply_fault(ram_addr0, mem0[ram_addr0]);
    if (!ram_rwbar1) mem1[ram_addr1] <= ram_wdata1;
    rdata1 <= apply_fault(ram_addr1, mem1[ram_addr1]);
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural March C- model ----------------
  // Each element as listed in the algorithm: count of ops, direction, and
  // for each op whether it reads and whether it uses the complement.
  int e_nops [6] = '{1, 2, 2, 2, 2, 1};
  bit e_up   [6] = '{1, 1, 1, 0, 0, 1};
  bit e_rd   [6][2] = '{'{0, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}};
  bit e_inv  [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
  logic [7:0] bgs [4] = '{8'h00, 8'h0F, 8'h33, 8'h55};

  logic [14:0] exp_q[$];   // {rd, addr[5:0], data[7:0]} per RUN cycle
  int m_cnt, m_first_op, m_first_addr, m_first_elem, m_first_bg;

  task automatic build_model();
    logic [7:0] mm [64];
    logic [7:0] v;
    int a, idx;
    bit rd;
    exp_q.delete();
    m_cnt = 0; m_first_op = -1; m_first_addr = 0; m_first_elem = 0; m_first_bg = 0;
    idx = 0;
    for (int b = 0; b < 4; b++)
      for (int e = 0; e < 6; e++)
        for (int k = 0; k < 64; k++) begin
          a = e_up[e] ? k : 63 - k;
          for (int o = 0; o < e_nops[e]; o++) begin
            rd = e_rd[e][o];
            v = bgs[b] ^ {8{e_inv[e][o]}};
            exp_q.push_back({rd, a[5:0], v});
            if (rd) begin
              if (apply_fault(a[5:0], mm[a]) !== v) begin
                if (m_first_op < 0) begin
                  m_first_op = idx; m_first_addr = a; m_first_elem = e; m_first_bg = b;
                end
                m_cnt++;
              end
            end else begin
              mm[a] = v;
            end
            idx++;
          end
        end
  endtask

  function automatic int sat_cnt(input int c);
    return (c > 255) ? 255 : c;
  endfunction

  // ---------------- cycle-by-cycle compare for dut0 ----------------
  always @(negedge clk) begin
    logic [14:0] op;
    if (!rst0) begin
      if (busy0) begin
        if (exp_q.size() > 0) begin
          op = exp_q.pop_front();
          chk("op_rwbar", ram_rwbar0, op[14]);
          chk("op_addr", ram_addr0, op[13:8]);
          if (!op[14]) chk("op_wdata", ram_wdata0, op[7:0]);
        end
      end else begin
        chk("idle_rwbar", ram_rwbar0, 1);
        chk("idle_addr", ram_addr0, 0);
        chk("idle_wdata", ram_wdata0, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int which, input bit drop);
    @(posedge clk); #1;
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    if (drop) begin
      if (which == 0) start0 = 1'b0; else start1 = 1'b0;
    end
  endtask

  // Counts busy cycles until done; flags any write after cycle index late_after.
  task automatic wait_done(input int which, input int drop_at, input int late_after,
                           output int cyc, output bit wrote_late);
    bit seen;
    cyc = 0; wrote_late = 1'b0; seen = 1'b0;
    for (int t = 0; t < 4000 && !seen; t++) begin
      @(negedge clk);
      if (which == 0 ? done0 : done1) begin
        seen = 1'b1;
      end else begin
        if ((which == 0 ? busy0 : busy1) == 1'b1) begin
          if (late_after >= 0 && cyc > late_after && ram_rwbar1 == 1'b0) wrote_late = 1'b1;
          cyc++;
        end
        if (drop_at >= 0 && cyc == drop_at) start0 = 1'b0;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout dut%0d busy_cycles=%0d done never seen", which, cyc);
    end
  endtask

  task automatic check_reset(input int which, input string tag);
    if (which == 0) begin
      chk({tag, "_busy"}, busy0, 0); chk({tag, "_done"}, done0, 0);
      chk({tag, "_fail"}, fail0, 0); chk({tag, "_faddr"}, fail_addr0, 0);
      chk({tag, "_felem"}, fail_elem0, 0); chk({tag, "_fbg"}, fail_bg0, 0);
      chk({tag, "_fcnt"}, fail_cnt0, 0); chk({tag, "_rwbar"}, ram_rwbar0, 1);
    end else begin
      chk({tag, "_busy"}, busy1, 0); chk({tag, "_done"}, done1, 0);
      chk({tag, "_fail"}, fail1, 0); chk({tag, "_faddr"}, fail_addr1, 0);
      chk({tag, "_felem"}, fail_elem1, 0); chk({tag, "_fbg"}, fail_bg1, 0);
      chk({tag, "_fcnt"}, fail_cnt1, 0); chk({tag, "_rwbar"}, ram_rwbar1, 1);
    end
  endtask

  task automatic set_fault(input bit en, input logic [5:0] a, input int b, input bit v);
    f_en = en; f_addr = a; f_bit = b; f_val = v;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int cyc;
    bit late;
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    for (int i = 0; i < 64; i++) begin mem0[i] = '0; mem1[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    check_reset(0, "por0");
    check_reset(1, "por1");

    // Fault-free run: 2560 RUN + 1 CHECK cycle
    set_fault(0, 6'h00, 0, 0);
    build_model();
    chk("model_len", exp_q.size(), 2560);
    chk("model_clean_cnt", m_cnt, 0);
    pulse_start(0, 1);
    wait_done(0, -1, -1, cyc, late);
    chk("clean_busy_cycles", cyc, 2561);
    chk("clean_done", done0, 1);
    chk("clean_fail", fail0, 0);
    chk("clean_cnt", fail_cnt0, 0);

    // Stuck-at-1 bit 3 at 0x2A, start held high through the run
    set_fault(1, 6'h2A, 3, 1);
    build_model();
    chk("model_sa1_addr", m_first_addr, 32'h2A);
    chk("model_sa1_elem", m_first_elem, 1);
    chk("model_sa1_bg", m_first_bg, 0);
    chk("model_sa1_op", m_first_op, 148);
    pulse_start(0, 0);
    wait_done(0, 2400, -1, cyc, late);
    chk("sa1_busy_cycles", cyc, 2561);
    chk("sa1_fail", fail0, 1);
    chk("sa1_faddr", fail_addr0, m_first_addr);
    chk("sa1_felem", fail_elem0, m_first_elem);
    chk("sa1_fbg", fail_bg0, m_first_bg);
    chk("sa1_cnt", fail_cnt0, sat_cnt(m_cnt));
    chk("sa1_cnt_gt1", fail_cnt0 > 8'd1, 1);
    repeat (4) begin
      @(negedge clk);
      chk("done_hold", done0, 1);
      chk("done_not_busy", busy0, 0);
    end

    // Restart from DONE clears results, then runs clean
    set_fault(0, 6'h00, 0, 0);
    build_model();
    pulse_start(0, 1);
    chk("restart_busy", busy0, 1);
    chk("restart_done", done0, 0);
    chk("restart_fail", fail0, 0);
    chk("restart_cnt", fail_cnt0, 0);
    chk("restart_faddr", fail_addr0, 0);
    wait_done(0, -1, -1, cyc, late);
    chk("restart_busy_cycles", cyc, 2561);
    chk("restart_end_fail", fail0, 0);

    // STOP_ON_FAIL instance with the same stuck-at-1 cell
    set_fault(1, 6'h2A, 3, 1);
    build_model();
    pulse_start(1, 1);
    wait_done(1, -1, m_first_op, cyc, late);
    chk("sof_busy_cycles", cyc, m_first_op + 2);
    chk("sof_busy_literal", cyc, 150);
    chk("sof_no_late_write", late, 0);
    chk("sof_done", done1, 1);
    chk("sof_fail", fail1, 1);
    chk("sof_cnt", fail_cnt1, 1);
    chk("sof_faddr", fail_addr1, 32'h2A);
    chk("sof_felem", fail_elem1, 1);
    chk("sof_fbg", fail_bg1, 0);

    // Stuck-at-0 bit 0 at 0x3F: first miscompare in M2
    set_fault(1, 6'h3F, 0, 0);
    build_model();
    chk("model_sa0_elem", m_first_elem, 2);
    chk("model_sa0_addr", m_first_addr, 32'h3F);
    pulse_start(0, 1);
    wait_done(0, -1, -1, cyc, late);
    chk("sa0_busy_cycles", cyc, 2561);
    chk("sa0_fail", fail0, 1);
    chk("sa0_faddr", fail_addr0, 32'h3F);
    chk("sa0_felem", fail_elem0, 2);
    chk("sa0_fbg", fail_bg0, 0);
    chk("sa0_cnt", fail_cnt0, sat_cnt(m_cnt));

    // Reset in the middle of a run, then a clean run
    set_fault(0, 6'h00, 0, 0);
    build_model();
    pulse_start(0, 1);
    repeat (299) @(posedge clk);
    #1 chk("midrun_busy", busy0, 1);
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    exp_q.delete();
    check_reset(0, "midrst");
    chk("midrst_addr", ram_addr0, 0);
    build_model();
    pulse_start(0, 1);
    wait_done(0, -1, -1, cyc, late);
    chk("post_rst_busy_cycles", cyc, 2561);
    chk("post_rst_fail", fail0, 0);
    chk("post_rst_cnt", fail_cnt0, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
